// File: rtl/unidade_controle.sv
// Sequencing control unit for the X/Y registers and the ULA: one instruction per start/busy/done handshake.
// Optional macro UC_SINGLE_STEP_EN adds i_step, which gates each SHIFT-state shift.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for i_start; latches opcode/amt when it arrives
// S_EXEC  | single execution cycle, outputs decoded from latched opcode
// S_SHIFT | remaining shift cycles of SHRY/SHLY, counted down in r_cnt
// S_DONE  | one-cycle done pulse, then back to S_IDLE
module unidade_controle #(
    parameter int AMT_W = 2
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_start,
`ifdef UC_SINGLE_STEP_EN
    input  logic             i_step,
`endif
    input  logic [2:0]       i_opcode,
    input  logic [AMT_W-1:0] i_amt,
    output logic [2:0]       o_funcX,
    output logic [2:0]       o_funcY,
    output logic [1:0]       o_selULA,
    output logic             o_busy,
    output logic             o_done
);

    localparam logic [2:0] F_HOLD   = 3'b000;
    localparam logic [2:0] F_LOAD   = 3'b001;
    localparam logic [2:0] F_SHIFTR = 3'b010;
    localparam logic [2:0] F_SHIFTL = 3'b011;
    localparam logic [2:0] F_RESET  = 3'b100;

    localparam logic [1:0] ULA_ADD   = 2'b00;
    localparam logic [1:0] ULA_SUB   = 2'b01;
    localparam logic [1:0] ULA_PASSX = 2'b10;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_LOADX = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_SHRY  = 3'b100;
    localparam logic [2:0] OP_SHLY  = 3'b101;
    localparam logic [2:0] OP_CLR   = 3'b110;
    localparam logic [2:0] OP_MOVE  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [2:0]       r_opcode;
    logic [AMT_W-1:0] r_amt;
    logic [AMT_W-1:0] r_cnt;

    logic       w_cnt_load;
    logic       w_cnt_dec;
    logic       w_step;
    logic       w_is_shift_op;
    logic [2:0] w_shift_func;
    logic [2:0] w_funcX;
    logic [2:0] w_funcY;
    logic [1:0] w_selULA;
    logic       w_busy;
    logic       w_done;

`ifdef UC_SINGLE_STEP_EN
    assign w_step = i_step;
`else
    assign w_step = 1'b1;
`endif

    assign w_is_shift_op = (r_opcode == OP_SHRY) || (r_opcode == OP_SHLY);
    assign w_shift_func  = (r_opcode == OP_SHLY) ? F_SHIFTL : F_SHIFTR;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_opcode <= '0;
            r_amt    <= '0;
            r_cnt    <= '0;
        end else begin
            if ((r_state == S_IDLE) && i_start) begin
                r_opcode <= i_opcode;
                r_amt    <= i_amt;
            end
            // EXEC already issued the first shift, so SHIFT owes amt-1 more
            if (w_cnt_load) begin
                r_cnt <= r_amt - AMT_W'(1);
            end else if (w_cnt_dec) begin
                r_cnt <= r_cnt - AMT_W'(1);
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_funcX      = F_HOLD;
        w_funcY      = F_HOLD;
        w_selULA     = ULA_ADD;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        w_cnt_load   = 1'b0;
        w_cnt_dec    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                w_busy = 1'b1;
                case (r_opcode)
                    OP_NOP:   ;
                    OP_LOADX: w_funcX = F_LOAD;
                    OP_ADD:   begin w_selULA = ULA_ADD;   w_funcY = F_LOAD; end
                    OP_SUB:   begin w_selULA = ULA_SUB;   w_funcY = F_LOAD; end
                    OP_SHRY,
                    OP_SHLY:  if (r_amt != '0) w_funcY = w_shift_func;
                    OP_CLR:   begin w_funcX = F_RESET;    w_funcY = F_RESET; end
                    OP_MOVE:  begin w_selULA = ULA_PASSX; w_funcY = F_LOAD; end
                    default:  ;
                endcase
                if (w_is_shift_op && (r_amt > AMT_W'(1))) begin
                    w_cnt_load   = 1'b1;
                    w_next_state = S_SHIFT;
                end else begin
                    w_next_state = S_DONE;
                end
            end
            S_SHIFT: begin
                w_busy = 1'b1;
                if (w_step) begin
                    w_funcY   = w_shift_func;
                    w_cnt_dec = 1'b1;
                    if (r_cnt == AMT_W'(1)) begin
                        w_next_state = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_busy       = 1'b1;
                w_done       = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Reset clears the datapath registers on the same edge that resets this FSM
    always_comb begin
        if (i_reset) begin
            o_funcX  = F_RESET;
            o_funcY  = F_RESET;
            o_selULA = ULA_ADD;
            o_busy   = 1'b0;
            o_done   = 1'b0;
        end else begin
            o_funcX  = w_funcX;
            o_funcY  = w_funcY;
            o_selULA = w_selULA;
            o_busy   = w_busy;
            o_done   = w_done;
        end
    end

endmodule

// File: tb/tb_unidade_controle.sv
// Bench for unidade_controle: each accepted instruction is expanded into its expected
// cycle-by-cycle output trace, and the DUT is compared against that trace every cycle.
module tb_unidade_controle;

    localparam int AMT_W = 2;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             step  = 1'b1;
    logic [2:0]       opcode = 3'b000;
    logic [AMT_W-1:0] amt = '0;
    logic [2:0]       funcX;
    logic [2:0]       funcY;
    logic [1:0]       selULA;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    unidade_controle #(.AMT_W(AMT_W)) dut (
        .i_clock  (clock),
        .i_reset  (reset),
        .i_start  (start),
`ifdef UC_SINGLE_STEP_EN
        .i_step   (step),
`endif
        .i_opcode (opcode),
        .i_amt    (amt),
        .o_funcX  (funcX),
        .o_funcY  (funcY),
        .o_selULA (selULA),
        .o_busy   (busy),
        .o_done   (done)
    );

    // One expected busy cycle; 'shift' marks a cycle that may be stalled by step=0
    typedef struct packed {
        logic [2:0] fx;
        logic [2:0] fy;
        logic [1:0] sel;
        logic       dn;
        logic       shift;
    } ent_t;

    ent_t trace[$];

    task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got busy/done/sel/fx/fy=%b required %b", tag, $time, obs, exp);
        end
    endtask

    task automatic expand(input logic [2:0] op, input int n);
        ent_t e;
        e = '0;
        case (op)
            3'd1: e.fx = 3'b001;
            3'd2: begin e.sel = 2'b00; e.fy = 3'b001; end
            3'd3: begin e.sel = 2'b01; e.fy = 3'b001; end
            3'd4: e.fy = (n != 0) ? 3'b010 : 3'b000;
            3'd5: e.fy = (n != 0) ? 3'b011 : 3'b000;
            3'd6: begin e.fx = 3'b100; e.fy = 3'b100; end
            3'd7: begin e.sel = 2'b10; e.fy = 3'b001; end
            default: ;
        endcase
        trace.push_back(e);
        if (op == 3'd4 || op == 3'd5) begin
            for (int i = 1; i < n; i++) begin
                e = '0;
                e.fy = (op == 3'd4) ? 3'b010 : 3'b011;
                e.shift = 1'b1;
                trace.push_back(e);
            end
        end
        e = '0;
        e.dn = 1'b1;
        trace.push_back(e);
    endtask

    // Drive one cycle's inputs, compare mid-cycle, then advance the model past the edge
    task automatic tick(input string tag, input logic r, input logic s,
                        input logic [2:0] op, input logic [AMT_W-1:0] a, input logic stp);
        logic [9:0] exp;
        logic       stalled;
        ent_t       e;
        @(negedge clock);
        reset  = r;
        start  = s;
        opcode = op;
        amt    = a;
        step   = stp;
        #1;
        stalled = 1'b0;
        if (r) begin
            exp = {1'b0, 1'b0, 2'b00, 3'b100, 3'b100};
        end else if (trace.size() == 0) begin
            exp = '0;
        end else begin
            e = trace[0];
`ifdef UC_SINGLE_STEP_EN
            stalled = e.shift && !stp;
`endif
            exp = {1'b1, e.dn, e.sel, e.fx, stalled ? 3'b000 : e.fy};
        end
        check(tag, {busy, done, selULA, funcX, funcY}, exp);
        if (r) begin
            trace.delete();
        end else if (trace.size() == 0) begin
            if (s) expand(op, int'(a));
        end else if (!stalled) begin
            void'(trace.pop_front());
        end
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) tick(tag, 1'b0, 1'b0, 3'd0, '0, 1'b1);
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [AMT_W-1:0] a, input int gap);
        tick(tag, 1'b0, 1'b1, op, a, 1'b1);
        idle(tag, gap);
    endtask

    initial begin
        tick("reset", 1'b1, 1'b0, 3'd0, '0, 1'b1);
        tick("reset", 1'b1, 1'b1, 3'd1, '0, 1'b1);
        idle("post_reset", 2);

        run_op("loadx", 3'd1, 2'd0, 3);
        run_op("shly3", 3'd5, 2'd3, 6);
        run_op("shly0", 3'd5, 2'd0, 3);
        run_op("shry1", 3'd4, 2'd1, 3);
        run_op("add",   3'd2, 2'd2, 3);
        run_op("sub",   3'd3, 2'd1, 3);
        run_op("move",  3'd7, 2'd0, 3);
        run_op("clr",   3'd6, 2'd0, 3);
        run_op("nop",   3'd0, 2'd3, 3);

        // start pulses during EXEC/SHIFT/DONE of SHRY 3 must not launch anything
        tick("shry_busy", 1'b0, 1'b1, 3'd4, 2'd3, 1'b1);
        tick("shry_busy", 1'b0, 1'b1, 3'd2, 2'd0, 1'b1);
        tick("shry_busy", 1'b0, 1'b1, 3'd1, 2'd0, 1'b1);
        tick("shry_busy", 1'b0, 1'b0, 3'd1, 2'd0, 1'b1);
        tick("shry_busy", 1'b0, 1'b1, 3'd6, 2'd0, 1'b1);
        idle("shry_busy", 3);

        // reset in the second SHIFT cycle aborts with no done pulse
        tick("shift_abort", 1'b0, 1'b1, 3'd5, 2'd3, 1'b1);
        tick("shift_abort", 1'b0, 1'b0, 3'd0, 2'd0, 1'b1);
        tick("shift_abort", 1'b0, 1'b0, 3'd0, 2'd0, 1'b1);
        tick("shift_abort", 1'b1, 1'b0, 3'd0, 2'd0, 1'b1);
        idle("shift_abort", 4);

`ifdef UC_SINGLE_STEP_EN
        tick("step_hold", 1'b0, 1'b1, 3'd4, 2'd3, 1'b0);
        tick("step_hold", 1'b0, 1'b0, 3'd0, 2'd0, 1'b0);
        tick("step_hold", 1'b0, 1'b0, 3'd0, 2'd0, 1'b0);
        tick("step_hold", 1'b0, 1'b0, 3'd0, 2'd0, 1'b1);
        tick("step_hold", 1'b0, 1'b0, 3'd0, 2'd0, 1'b0);
        tick("step_hold", 1'b0, 1'b0, 3'd0, 2'd0, 1'b1);
        idle("step_hold", 3);
`endif

        // start held high: single-cycle ops relaunch every third cycle
        for (int i = 0; i < 9; i++) tick("b2b", 1'b0, 1'b1, 3'd1, 2'd0, 1'b1);
        idle("b2b", 2);

        for (int i = 0; i < 1500; i++) begin
            tick("random",
                 ($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 1) == 1),
                 3'($urandom_range(0, 7)),
                 AMT_W'($urandom_range(0, (1 << AMT_W) - 1)),
                 ($urandom_range(0, 3) != 0));
        end
        idle("drain", 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/unidade_controle.md
Name: unidade_controle

Overview:
- Sequencing control unit directly upstream of the X/Y datapath registers and the ULA.
- Accepts one instruction at a time through a start/busy/done handshake.
- For each instruction it drives the 3-bit func codes of register X and register Y plus the ULA operation select, cycle by cycle, until the instruction completes.
- Multi-cycle shift instructions are sequenced with an internal down-counter.

Parameters:
AMT_W, 2, width of shift-amount field and internal shift counter (max shifts = 2^AMT_W - 1)

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  instruction request; sampled only in IDLE
opcode  input  3  instruction code, latched with start
amt  input  AMT_W  shift amount for SHRY/SHLY, latched with start
funcX  output  3  func code to register X
funcY  output  3  func code to register Y
selULA  output  2  ULA op: 00 ADD (X+Y), 01 SUB (Y-X), 10 PASSX, 11 PASSY
busy  output  1  high while an instruction is in progress (any state except IDLE)
done  output  1  one-cycle completion pulse

Behaviour:
- Func encoding: HOLD 000, LOAD 001, SHIFTR 010, SHIFTL 011, RESET 100. Values 101-111 are never driven.
- Outputs are decoded combinationally from state, latched instruction and counter only; no combinational path from start/opcode/amt.
- Default in every cycle not listed below: funcX = funcY = HOLD, selULA = 00.
- States:
  - IDLE: busy=0, done=0. If start=1, latch opcode/amt and go to EXEC. If start=0, stay.
  - EXEC: one cycle, outputs per opcode:
    - 000 NOP: nothing.
    - 001 LOADX: funcX=LOAD.
    - 010 ADD: selULA=00, funcY=LOAD.
    - 011 SUB: selULA=01, funcY=LOAD.
    - 100 SHRY: funcY=SHIFTR if amt!=0.
    - 101 SHLY: funcY=SHIFTL if amt!=0.
    - 110 CLR: funcX=RESET, funcY=RESET.
    - 111 MOVE: selULA=10, funcY=LOAD.
    - Exit from EXEC: for SHRY/SHLY with amt>=2, load counter=amt-1 and go to SHIFT. All other cases (including amt 0 or 1) go to DONE.
  - SHIFT: drive the same shift func on funcY and decrement the counter. When counter==1 this cycle, go to DONE; otherwise stay.
  - DONE: done=1 for exactly one cycle, outputs HOLD, then go to IDLE.
- Latency:
  - start sampled at edge k means EXEC in cycle k..k+1, and the target register updates at edge k+1.
  - done is high in cycle k+1..k+2.
  - Single-cycle opcodes take 2 cycles start-to-done. SHRY/SHLY with amt=n>=1 take n+1 cycles. amt=0 takes 2 cycles with zero shifts.
  - Exactly amt shift cycles are issued, never more.
- start while busy=1 is ignored and not queued. start may be asserted in the DONE cycle, but it is not sampled until IDLE.
- Back-to-back operation: start held high continuously gives a new EXEC every 3 cycles for single-cycle ops (IDLE, EXEC, DONE).
- Reset:
  - While reset=1, funcX=funcY=RESET (100), selULA=00, busy=0, done=0. This overrides all state decoding so the datapath clears in the same edge.
  - At the reset edge: state=IDLE, counter=0, latched opcode=000, latched amt=0.
  - Reset mid-instruction aborts it with no done pulse.
  - After reset deasserts, outputs are HOLD in IDLE.
- Counter arithmetic is unsigned AMT_W bits and never wraps, because SHIFT exits at counter==1.

Optional Feature:
UC_SINGLE_STEP_EN
- Defined: adds input port step (1 bit, after start). In SHIFT state, a shift is issued and the counter decremented only in cycles with step=1. Cycles with step=0 drive HOLD and keep the state. EXEC and all other states are unaffected.
- Not defined: no step port; SHIFT issues one shift every cycle as described above.

Test Plan:
- Reset: assert reset 2 cycles -> funcX=funcY=100 during reset, busy=0, done=0. After release: HOLD, IDLE.
- LOADX: start=1, opcode=001 at edge k -> funcX=001 in cycle k..k+1 only, done=1 in cycle k+1..k+2, busy high 2 cycles.
- SHLY amt=3: start with opcode=101, amt=11 -> funcY=011 for exactly 3 consecutive cycles, then done; with amt=00 -> zero shift cycles, done after 2 cycles.
- ADD/SUB/MOVE: opcode 010/011/111 -> selULA=00/01/10 respectively, with funcY=001 in the same single cycle.
- start pulsed during SHIFT of SHRY amt=3 -> ignored; exactly 3 SHIFTR cycles, one done pulse, no second instruction.
- Reset asserted in the 2nd SHIFT cycle -> funcY=100 that cycle, no done pulse, IDLE afterwards; with UC_SINGLE_STEP_EN, step=0 in SHIFT -> funcY=000 and counter held.
